// File: rtl/spi_master_mode_pkg.sv
// Shared definitions for the bit-bang SPI master: FSM encodings and mode-bit positions.
package spi_master_mode_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // mode = {CPOL, CPHA}
    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

endpackage

// File: rtl/spi_master_mode_shift.sv
// W-bit shift register used for both TX and RX: the outgoing bit leaves one end while
// the sampled MISO bit enters the other; direction chooses MSB- or LSB-first.
module spi_shift #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         bit_i,
    input  logic         lsb_i,
    output logic [W-1:0] shifted_o,
    output logic         top_o,
    output logic         next_o
);

    logic [W-1:0] data_q, data_d;

    always_comb begin
        shifted_o = lsb_i ? {bit_i, data_q[W-1:1]} : {data_q[W-2:0], bit_i};
        top_o     = lsb_i ? data_q[0] : data_q[W-1];
        next_o    = lsb_i ? data_q[1] : data_q[W-2];
        data_d    = data_q;
        if (load_i) begin
            data_d = load_val_i;
        end else if (shift_i) begin
            data_d = shifted_o;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/spi_master_mode.sv
// Bit-bang SPI master, all four modes, multi-CS, CS-held bursts, one half-period per step_i.
// Define SPI_MASTER_LSB_EN to add the lsb_i port for per-word LSB-first order.
//
// state    | meaning
// IDLE     | CS high, sclk at CPOL of last word, waiting for a word
// START    | CS asserted for one step; CPHA=0 has first bit on mosi
// SHIFT    | 2W sclk toggles, reload in place for a burst
// STOP     | CS still low for one step before release
module spi_master_mode
    import spi_master_mode_pkg::*;
#(
    parameter  int W        = 8,
    parameter  int CS_COUNT = 1,
    localparam int SW       = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                step_i,
    input  logic [W-1:0]        in_i,
    input  logic [SW-1:0]       sel_i,
    input  logic [1:0]          mode_i,
    output logic                get_o,
    input  logic                empty_i,
    output logic [W-1:0]        out_o,
    output logic                put_o,
    output logic [CS_COUNT-1:0] cs_n_o,
    output logic                sclk_o,
    output logic                mosi_o,
    input  logic                miso_i
`ifdef SPI_MASTER_LSB_EN
    ,
    input  logic                lsb_i
`endif
);

    localparam int             HW      = $clog2(2 * W);
    localparam logic [HW-1:0]  REM_TOP = HW'(2 * W - 1);

    logic [1:0]          state_q, state_d;
    logic [HW-1:0]       rem_q, rem_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [CS_COUNT-1:0] cs_n_q, cs_n_d, cs_decode;
    logic                sclk_q, sclk_d, mosi_q, mosi_d, rx_bit_q, rx_bit_d, put_q, put_d;
    logic [W-1:0]        out_q, out_d;
    logic                lsb_sel, first_bit, burst_ok, leading;
    logic                sh_load, sh_shift, sh_in, sh_top, sh_next;
    logic [W-1:0]        sh_shifted;

`ifdef SPI_MASTER_LSB_EN
    assign lsb_sel = lsb_i;
`else
    assign lsb_sel = 1'b0;
`endif

    assign first_bit = lsb_sel ? in_i[0] : in_i[W-1];

    // A select beyond CS_COUNT decodes to no asserted line.
    always_comb begin
        for (int i = 0; i < CS_COUNT; i++) begin
            cs_decode[i] = (int'(sel_i) != i);
        end
    end

    spi_shift #(.W(W)) u_shift (
        .clock      (clock),
        .reset      (reset),
        .load_i     (sh_load),
        .load_val_i (in_i),
        .shift_i    (sh_shift),
        .bit_i      (sh_in),
        .lsb_i      (lsb_q),
        .shifted_o  (sh_shifted),
        .top_o      (sh_top),
        .next_o     (sh_next)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        lsb_d    = lsb_q;
        sel_d    = sel_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        rx_bit_d = rx_bit_q;
        put_d    = 1'b0;
        out_d    = out_q;
        get_o    = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        // CPHA=0 samples on the leading edge and shifts later; CPHA=1 shifts in on the sample edge.
        sh_in    = cpha_q ? miso_i : rx_bit_q;
        burst_ok = !empty_i && (sel_i == sel_q) && (mode_i == {cpol_q, cpha_q});
        // rem counts down from 2W-1, so odd rem marks a leading edge.
        leading  = rem_q[0];

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol_q;
                mosi_d = 1'b0;
                cs_n_d = '1;
                if (step_i && !empty_i) begin
                    get_o   = 1'b1;
                    sh_load = 1'b1;
                    cpol_d  = mode_i[MODE_CPOL];
                    cpha_d  = mode_i[MODE_CPHA];
                    lsb_d   = lsb_sel;
                    sel_d   = sel_i;
                    cs_n_d  = cs_decode;
                    sclk_d  = mode_i[MODE_CPOL];
                    mosi_d  = mode_i[MODE_CPHA] ? 1'b0 : first_bit;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (step_i) begin
                    rem_d   = REM_TOP;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (step_i) begin
                    sclk_d = !sclk_q;
                    rem_d  = rem_q - HW'(1);
                    if (leading) begin
                        if (cpha_q) mosi_d = sh_top;
                        else        rx_bit_d = miso_i;
                    end else begin
                        sh_shift = 1'b1;
                        if (!cpha_q) mosi_d = sh_next;
                    end
                    if (rem_q == '0) begin
                        put_d = 1'b1;
                        out_d = sh_shifted;
                        if (burst_ok) begin
                            get_o   = 1'b1;
                            sh_load = 1'b1;
                            lsb_d   = lsb_sel;
                            rem_d   = REM_TOP;
                            if (!cpha_q) mosi_d = first_bit;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (step_i) begin
                    cs_n_d  = '1;
                    mosi_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            sel_q    <= '0;
            cs_n_q   <= '1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            rx_bit_q <= 1'b0;
            put_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            lsb_q    <= lsb_d;
            sel_q    <= sel_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            rx_bit_q <= rx_bit_d;
            put_q    <= put_d;
            out_q    <= out_d;
        end
    end

    assign cs_n_o = cs_n_q;
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign put_o  = put_q;
    assign out_o  = out_q;

endmodule

// File: tb/tb_spi_master_mode.sv
// Directed bench for spi_master_mode (W=8, CS_COUNT=4) with MISO looped back from MOSI.
module tb_spi_master_mode;

    logic       clock = 1'b0;
    logic       reset, step, empty, get, put, sclk, mosi, miso;
    logic [7:0] din, dout;
    logic [1:0] sel, mode;
    logic [3:0] cs_n;
`ifdef SPI_MASTER_LSB_EN
    logic       lsb;
`endif

    always #5 clock = ~clock;

    spi_master_mode #(.W(8), .CS_COUNT(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .step_i  (step),
        .in_i    (din),
        .sel_i   (sel),
        .mode_i  (mode),
        .get_o   (get),
        .empty_i (empty),
        .out_o   (dout),
        .put_o   (put),
        .cs_n_o  (cs_n),
        .sclk_o  (sclk),
        .mosi_o  (mosi),
        .miso_i  (miso)
`ifdef SPI_MASTER_LSB_EN
        ,
        .lsb_i   (lsb)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] q_word[8];
    logic [1:0] q_sel[8];
    logic [1:0] q_mode;
    logic       q_lsb;
    int         q_n, q_idx;

    int         cyc, steps, put_cnt, get_cnt, rises, falls, cs_low_steps, high_between, viol;
    int         get_tick, put_tick, cs_hist_n;
    int         put_step[4];
    logic [7:0] outs[4];
    logic [3:0] cs_hist[8];
    logic [7:0] cap;
    logic       first_mosi, first_seen, sclk_at_cs_low, prev_sclk, prev_step;
    logic [3:0] prev_cs;
    logic       cur_cpol, cur_cpha, cur_lsb;

    task automatic clear_mon();
        steps = 0; put_cnt = 0; get_cnt = 0; rises = 0; falls = 0;
        cs_low_steps = 0; high_between = 0; viol = 0; get_tick = 0; put_tick = 0;
        cs_hist_n = 0; cap = 8'h00; first_mosi = 1'b0; first_seen = 1'b0;
        sclk_at_cs_low = 1'b0; prev_sclk = sclk; prev_cs = cs_n; prev_step = 1'b0;
        for (int i = 0; i < 4; i++) begin outs[i] = 8'h00; put_step[i] = 0; end
    endtask

    task automatic set_words(input int n, input logic [1:0] md, input logic lsb_first);
        q_n = n; q_idx = 0; q_mode = md; q_lsb = lsb_first;
        cur_cpol = md[1]; cur_cpha = md[0]; cur_lsb = lsb_first;
        clear_mon();
    endtask

    // One clock: observe registered outputs, then drive inputs for the next edge.
    task automatic tick(input logic stp);
        logic leading;
        @(negedge clock);
        if (put) begin
            if (!prev_step) viol++;
            if (put_cnt < 4) begin outs[put_cnt] = dout; put_step[put_cnt] = steps; end
            put_cnt++;
            put_tick = cyc;
        end
        if (sclk !== prev_sclk && prev_cs != 4'hF) begin
            if (sclk) rises++; else falls++;
            leading = (prev_sclk == cur_cpol);
            if (leading != cur_cpha) begin
                if (!first_seen) begin first_mosi = mosi; first_seen = 1'b1; end
                cap = cur_lsb ? {mosi, cap[7:1]} : {cap[6:0], mosi};
            end
        end
        if (cs_n !== prev_cs) begin
            if (cs_hist_n < 8) cs_hist[cs_hist_n] = cs_n;
            cs_hist_n++;
            if (prev_cs == 4'hF) sclk_at_cs_low = sclk;
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
        miso = mosi;
        step = stp;
        if (stp) begin
            steps++;
            if (cs_n != 4'hF) cs_low_steps++;
            if (cs_n == 4'hF && cs_hist_n == 2) high_between++;
        end
        if (q_idx < q_n) begin
            empty = 1'b0; din = q_word[q_idx]; sel = q_sel[q_idx]; mode = q_mode;
        end else begin
            empty = 1'b1; din = 8'h00; sel = 2'd0; mode = q_mode;
        end
`ifdef SPI_MASTER_LSB_EN
        lsb = q_lsb;
`endif
        #1;
        if (get) begin
            if (!stp) viol++;
            get_cnt++;
            get_tick = cyc;
            q_idx++;
        end
        prev_step = stp;
        cyc++;
    endtask

    task automatic run(input int cycles, input int div);
        for (int i = 0; i < cycles; i++) tick((i % div) == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; step = 1'b0; empty = 1'b1; din = 8'h00; sel = 2'd0; mode = 2'd0; miso = 1'b0;
        q_n = 0; q_idx = 0; q_mode = 2'd0; q_lsb = 1'b0;
`ifdef SPI_MASTER_LSB_EN
        lsb = 1'b0;
`endif
        repeat (3) @(negedge clock);
        checks++; if (cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs_n: got %b want 1111", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", dout); end
        checks++; if ({put, get} !== 2'b00) begin errors++; $display("FAIL reset_put_get: got %b want 00", {put, get}); end
        reset = 1'b0;
    endtask

    task automatic test_mode0();
        q_word[0] = 8'hA5; q_sel[0] = 2'd0;
        set_words(1, 2'b00, 1'b0);
        run(60, 2);
        checks++; if (rises !== 8) begin errors++; $display("FAIL mode0_rises: got %0d want 8", rises); end
        checks++; if (put_cnt !== 1) begin errors++; $display("FAIL mode0_puts: got %0d want 1", put_cnt); end
        checks++; if (outs[0] !== 8'hA5) begin errors++; $display("FAIL mode0_out: got %h want a5", outs[0]); end
        checks++; if (cap !== 8'hA5) begin errors++; $display("FAIL mode0_mosi: got %h want a5", cap); end
        checks++; if (cs_low_steps !== 18) begin errors++; $display("FAIL mode0_cs_steps: got %0d want 18", cs_low_steps); end
        checks++; if (cs_hist[0] !== 4'b1110) begin errors++; $display("FAIL mode0_cs_sel: got %b want 1110", cs_hist[0]); end
    endtask

    task automatic test_mode3();
        q_word[0] = 8'hA5; q_sel[0] = 2'd0;
        set_words(1, 2'b11, 1'b0);
        run(60, 2);
        checks++; if (sclk_at_cs_low !== 1'b1) begin errors++; $display("FAIL mode3_idle_before: got %b want 1", sclk_at_cs_low); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL mode3_idle_after: got %b want 1", sclk); end
        checks++; if (falls !== 8) begin errors++; $display("FAIL mode3_falls: got %0d want 8", falls); end
        checks++; if (outs[0] !== 8'hA5) begin errors++; $display("FAIL mode3_out: got %h want a5", outs[0]); end
        checks++; if (cap !== 8'hA5) begin errors++; $display("FAIL mode3_mosi: got %h want a5", cap); end
    endtask

    task automatic test_back_to_back();
        q_word[0] = 8'h01; q_word[1] = 8'h80; q_word[2] = 8'hFF;
        q_sel[0] = 2'd0; q_sel[1] = 2'd0; q_sel[2] = 2'd0;
        set_words(3, 2'b01, 1'b0);
        run(120, 2);
        checks++; if (put_cnt !== 3) begin errors++; $display("FAIL burst_puts: got %0d want 3", put_cnt); end
        checks++; if ({outs[0], outs[1], outs[2]} !== 24'h0180FF) begin
            errors++; $display("FAIL burst_outs: got %h %h %h want 01 80 ff", outs[0], outs[1], outs[2]); end
        checks++; if (rises + falls !== 48) begin errors++; $display("FAIL burst_half_periods: got %0d want 48", rises + falls); end
        checks++; if (cs_hist_n !== 2) begin errors++; $display("FAIL burst_cs_changes: got %0d want 2", cs_hist_n); end
        checks++; if (cs_low_steps !== 50) begin errors++; $display("FAIL burst_cs_steps: got %0d want 50", cs_low_steps); end
        checks++; if ((put_step[1] - put_step[0]) !== 16 || (put_step[2] - put_step[1]) !== 16) begin
            errors++; $display("FAIL burst_spacing: got %0d %0d want 16 16", put_step[1] - put_step[0], put_step[2] - put_step[1]); end
    endtask

    task automatic test_cs_select();
        q_word[0] = 8'h3C; q_word[1] = 8'hC3; q_sel[0] = 2'd2; q_sel[1] = 2'd3;
        set_words(2, 2'b00, 1'b0);
        run(100, 2);
        checks++; if (cs_hist_n !== 4) begin errors++; $display("FAIL cs_changes: got %0d want 4", cs_hist_n); end
        checks++; if ({cs_hist[0], cs_hist[1], cs_hist[2], cs_hist[3]} !== 16'b1011_1111_0111_1111) begin
            errors++; $display("FAIL cs_sequence: got %b %b %b %b want 1011 1111 0111 1111", cs_hist[0], cs_hist[1], cs_hist[2], cs_hist[3]); end
        checks++; if (high_between < 1) begin errors++; $display("FAIL cs_gap: got %0d want >=1", high_between); end
        checks++; if (put_cnt !== 2 || outs[1] !== 8'hC3) begin
            errors++; $display("FAIL cs_puts: got %0d/%h want 2/c3", put_cnt, outs[1]); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        q_word[0] = 8'h77; q_sel[0] = 2'd0;
        set_words(1, 2'b00, 1'b0);
        while ((rises + falls) < 5 && n < 100) begin tick((n % 2) == 0); n++; end
        checks++; if ((rises + falls) < 5) begin errors++; $display("FAIL rstmid_reach: got %0d toggles want 5", rises + falls); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (cs_n !== 4'hF || sclk !== 1'b0 || mosi !== 1'b0 || put !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got cs=%b sclk=%b mosi=%b put=%b want 1111 0 0 0", cs_n, sclk, mosi, put); end
        reset = 1'b0;
        set_words(0, 2'b00, 1'b0);
        run(40, 2);
        checks++; if (put_cnt !== 0) begin errors++; $display("FAIL rstmid_no_put: got %0d want 0", put_cnt); end
        q_word[0] = 8'h5A; q_sel[0] = 2'd0;
        set_words(1, 2'b00, 1'b0);
        run(60, 2);
        checks++; if (put_cnt !== 1 || outs[0] !== 8'h5A) begin
            errors++; $display("FAIL rstmid_next: got %0d/%h want 1/5a", put_cnt, outs[0]); end
    endtask

    task automatic test_step_high();
        q_word[0] = 8'h96; q_sel[0] = 2'd0;
        set_words(1, 2'b00, 1'b0);
        run(30, 1);
        // put is observed one tick after the edge that raised it; that edge is 2W+1 after the accept edge
        checks++; if ((put_tick - 1 - get_tick) !== 17) begin
            errors++; $display("FAIL stephigh_latency: got %0d want 17", put_tick - 1 - get_tick); end
        checks++; if (outs[0] !== 8'h96 || cap !== 8'h96) begin
            errors++; $display("FAIL stephigh_data: got out=%h mosi=%h want 96", outs[0], cap); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL get_put_without_step: got %0d want 0", viol); end
    endtask

`ifdef SPI_MASTER_LSB_EN
    task automatic test_lsb();
        q_word[0] = 8'h01; q_sel[0] = 2'd0;
        set_words(1, 2'b00, 1'b1);
        run(60, 2);
        checks++; if (first_mosi !== 1'b1) begin errors++; $display("FAIL lsb_first_bit: got %b want 1", first_mosi); end
        checks++; if (outs[0] !== 8'h01 || cap !== 8'h01) begin
            errors++; $display("FAIL lsb_data: got out=%h mosi=%h want 01", outs[0], cap); end
    endtask
`endif

    initial begin
        cyc = 0;
        cur_cpol = 1'b0; cur_cpha = 1'b0; cur_lsb = 1'b0;
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_cs_select();
        test_reset_mid();
        test_step_high();
`ifdef SPI_MASTER_LSB_EN
        test_lsb();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
